// File: rtl/dir_sched.sv
// dir_sched: route-command scheduler between UART_wrapper and the command processor.
// Buffers 16-bit commands in a DEPTH-entry FIFO and presents them one 2-bit
// direction field at a time (LSB first) over a dir_vld/dir_nxt handshake.
// Optional status outputs (occupancy, stall_sticky) are enabled by defining
// the macro DIR_SCHED_STATUS_EN.
module dir_sched #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        flush,
  input  logic        dir_nxt,
  output logic        dir_vld,
  output logic [1:0]  dir,
  output logic        cmd_busy
`ifdef DIR_SCHED_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   stall_sticky
`endif
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned FIELDS = 16 / 2;
  localparam int unsigned FW     = $clog2(FIELDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_END,
    S_NEXT
  } state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   shreg;
  logic [15:0]   shreg_nxt;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic          vld_nxt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Accept a command whenever there is room; suppressed by flush and reset.
  assign clr_cmd_rdy = cmd_rdy & ~full & ~flush & ~rst;
  assign push        = clr_cmd_rdy;

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd;
    end
  end

  // Next FIFO count: push and pop on the same edge cancel.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Next-state and field-unpacking logic.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    fcnt_nxt  = fcnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pop       = 1'b1;
        shreg_nxt = mem[rd_ptr];
        fcnt_nxt  = '0;
        state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (shreg[1:0] == 2'b00) begin
          state_nxt = S_END;
        end else if (dir_nxt) begin
          shreg_nxt = {2'b00, shreg[15:2]};
          fcnt_nxt  = fcnt + FW'(1);
          if (fcnt == FW'(FIELDS - 1)) state_nxt = S_NEXT;
        end
      end
      S_END: begin
        if (dir_nxt) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = empty ? S_IDLE : S_LOAD;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
    end
  end

  assign vld_nxt = (state_nxt == S_ACTIVE) || (state_nxt == S_END);

  // State, shift register and registered consumer-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      fcnt     <= '0;
      dir_vld  <= 1'b0;
      dir      <= 2'b00;
      cmd_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      fcnt     <= fcnt_nxt;
      dir_vld  <= vld_nxt;
      dir      <= vld_nxt ? shreg_nxt[1:0] : 2'b00;
      cmd_busy <= (state_nxt != S_IDLE) || (count_nxt != '0);
    end
  end

`ifdef DIR_SCHED_STATUS_EN
  // Status: registered occupancy and sticky flag for host stalls on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy    <= '0;
      stall_sticky <= 1'b0;
    end else begin
      occupancy <= count_nxt;
      if (flush) begin
        stall_sticky <= 1'b0;
      end else if (cmd_rdy && full) begin
        stall_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule
